mcu_wb_arbiter: RTL and testbench

Write-port arbiter for the control-processor integer register file. It shares the single register-file write port among several writeback sources (ALU, load unit, multiply/divide, CSR) using round-robin arbitration. It registers the winning write into a one-stage writeback pipeline that drives the register file's `we`/`waddr`/`wdata`. The same stage is exported as a bypass source and a busy mask for hazard logic.

---
 rtl/mcu_wb_arbiter.sv | 111 +++++++++++
 tb/tb_mcu_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_wb_arbiter.sv
// Round-robin arbiter for the integer register-file write port. It registers the
// winning write into a single writeback stage that also feeds bypass and busy logic.
module mcu_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*5-1:0]    req_rd,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [2:0]              grant_id,
    output logic [31:0]             busy_mask
);

    logic [2:0]         rr_ptr;
    logic [2:0]         rr_ptr_nxt;
    logic [NUM_REQ-1:0] wr_req_p0;
    logic [NUM_REQ-1:0] x0_req_p0;
    logic               vld_p0;
    logic [2:0]         gnt_idx_p0;
    logic [4:0]         gnt_rd_p0;
    logic [XLEN-1:0]    gnt_data_p0;

    logic               vld_p1;
    logic [4:0]         rd_p1;
    logic [XLEN-1:0]    data_p1;
    logic [2:0]         gnt_idx_p1;

    // ---- stage p0: request classification and round-robin selection ----
    always_comb begin
        wr_req_p0 = '0;
        x0_req_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_req_p0[i] = req_valid[i] && (req_rd[5*i +: 5] != 5'd0);
            x0_req_p0[i] = req_valid[i] && (req_rd[5*i +: 5] == 5'd0);
        end
    end

    // Scan from the farthest offset down so the nearest requester to rr_ptr wins.
    always_comb begin
        vld_p0     = 1'b0;
        gnt_idx_p0 = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (wr_req_p0[(int'(rr_ptr) + k) % NUM_REQ]) begin
                vld_p0     = 1'b1;
                gnt_idx_p0 = 3'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        gnt_rd_p0   = req_rd[int'(gnt_idx_p0)*5 +: 5];
        gnt_data_p0 = req_data[int'(gnt_idx_p0)*XLEN +: XLEN];
    end

    // x0 writes are sunk here without touching the port; reset masks every handshake.
    always_comb begin
        req_ready = '0;
        if (rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = x0_req_p0[i] || (vld_p0 && (gnt_idx_p0 == 3'(i)));
            end
        end
    end

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (vld_p0) begin
            rr_ptr_nxt = (int'(gnt_idx_p0) == NUM_REQ - 1) ? 3'd0 : gnt_idx_p0 + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // ---- stage p1: writeback register driving the register file ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            rd_p1      <= '0;
            data_p1    <= '0;
            gnt_idx_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                rd_p1      <= gnt_rd_p0;
                data_p1    <= gnt_data_p0;
                gnt_idx_p1 <= gnt_idx_p0;
            end
        end
    end

    always_comb begin
        rf_we     = vld_p1;
        rf_waddr  = rd_p1;
        rf_wdata  = data_p1;
        grant_id  = gnt_idx_p1;
        busy_mask = vld_p1 ? (32'd1 << rd_p1) : 32'd0;
    end

endmodule

// File: tb/tb_mcu_wb_arbiter.sv
// Directed bench for mcu_wb_arbiter: a behavioural round-robin model checked every
// cycle, plus literal expectations for the reset, fairness, x0, ordering and reset-drop cases.
module tb_mcu_wb_arbiter;

    localparam int N = 3;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*5-1:0]  req_rd = '0;
    logic [N*XLEN-1:0] req_data = '0;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [2:0]      grant_id;
    logic [31:0]     busy_mask;

    int n_cmp = 0;
    int n_bad = 0;

    mcu_wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_data(req_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .grant_id(grant_id), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file written by the DUT outputs, as the real one would be.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end

    // Behavioural model: first nonzero-rd valid requester at or after the pointer.
    function automatic int winner(input int ptr, input logic [N-1:0] v, input logic [N*5-1:0] rd);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (v[j] && rd[j*5 +: 5] != 5'd0) return j;
        end
        return -1;
    endfunction

    int          m_ptr  = 0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [2:0]  m_gid  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr  <= 0;
            m_we   <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
            m_gid  <= '0;
        end else if (winner(m_ptr, req_valid, req_rd) >= 0) begin
            m_we   <= 1'b1;
            m_addr <= req_rd[winner(m_ptr, req_valid, req_rd)*5 +: 5];
            m_data <= req_data[winner(m_ptr, req_valid, req_rd)*XLEN +: XLEN];
            m_gid  <= 3'(winner(m_ptr, req_valid, req_rd));
            m_ptr  <= (winner(m_ptr, req_valid, req_rd) + 1) % N;
        end else begin
            m_we <= 1'b0;
        end
    end

    function automatic logic [N-1:0] exp_ready(input logic rn, input int ptr,
                                                input logic [N-1:0] v, input logic [N*5-1:0] rd);
        logic [N-1:0] r;
        r = '0;
        if (rn) begin
            for (int i = 0; i < N; i++) begin
                r[i] = v[i] && (rd[i*5 +: 5] == 5'd0 || winner(ptr, v, rd) == i);
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        chk("m_ready", 32'(req_ready), 32'(exp_ready(rst_n, m_ptr, req_valid, req_rd)));
        chk("m_we", 32'(rf_we), 32'(m_we));
        chk("m_waddr", 32'(rf_waddr), 32'(m_addr));
        chk("m_wdata", rf_wdata, m_data);
        chk("m_gid", 32'(grant_id), 32'(m_gid));
        chk("m_busy", busy_mask, m_we ? (32'd1 << m_addr) : 32'd0);
        chk("no_x0_write", 32'(rf_we && rf_waddr == 5'd0), 32'd0);
    end

    task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
        req_valid[i]          = v;
        req_rd[i*5 +: 5]      = rd;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    int gseq [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int wr_cnt [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) wr_cnt[i] = 0;

        // Reset with every requester valid.
        #1 rst_n = 1'b0;
        set_req(0, 1'b1, 5'd1, 32'hA000_0001);
        set_req(1, 1'b1, 5'd2, 32'hA000_0002);
        set_req(2, 1'b1, 5'd3, 32'hA000_0003);
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;
        #1 chk("first_ready", 32'(req_ready), 32'b001);

        // Fairness: nine back-to-back grants.
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            if (k == 8) begin
                #1 req_valid = '0;
            end
            @(negedge clk);
            chk("fair_gid", 32'(grant_id), 32'(gseq[k]));
            chk("fair_waddr", 32'(rf_waddr), 32'(k % 3 + 1));
            chk("fair_wdata", rf_wdata, 32'hA000_0000 + 32'(k % 3 + 1));
            if (rf_we) wr_cnt[rf_waddr[1:0]]++;
        end
        @(negedge clk);
        chk("fair_idle_we", 32'(rf_we), 32'd0);
        for (int r = 1; r < 4; r++) chk("fair_count", 32'(wr_cnt[r]), 32'd3);

        // Single write from requester 1.
        drive_edge();
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1 chk("single_ready", 32'(req_ready), 32'b010);
        drive_edge();
        req_valid = '0;
        @(negedge clk);
        chk("single_we", 32'(rf_we), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd5);
        chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("single_busy", busy_mask, 32'h0000_0020);
        chk("single_gid", 32'(grant_id), 32'd1);
        drive_edge();
        @(negedge clk);
        chk("single_we_off", 32'(rf_we), 32'd0);

        // x0 request alongside a real write.
        drive_edge();
        set_req(0, 1'b1, 5'd0, 32'h0000_0BAD);
        set_req(2, 1'b1, 5'd7, 32'h0000_0077);
        #1 chk("x0_ready", 32'(req_ready), 32'b101);
        drive_edge();
        req_valid = '0;
        @(negedge clk);
        chk("x0_we", 32'(rf_we), 32'd1);
        chk("x0_waddr", 32'(rf_waddr), 32'd7);
        chk("x0_gid", 32'(grant_id), 32'd2);

        // Two writes to the same rd, pointer back at 0.
        drive_edge();
        set_req(0, 1'b1, 5'd9, 32'h0000_0011);
        set_req(1, 1'b1, 5'd9, 32'h0000_0022);
        #1 chk("same_ready0", 32'(req_ready), 32'b001);
        drive_edge();
        req_valid[0] = 1'b0;
        #1 chk("same_ready1", 32'(req_ready), 32'b010);
        @(negedge clk);
        chk("same_first", rf_wdata, 32'h0000_0011);
        chk("same_first_addr", 32'(rf_waddr), 32'd9);
        drive_edge();
        req_valid = '0;
        @(negedge clk);
        chk("same_second", rf_wdata, 32'h0000_0022);
        drive_edge();
        drive_edge();
        chk("same_rf_x9", rf_mem[9], 32'h0000_0022);

        // Mid-operation reset drops the write in the output stage.
        drive_edge();
        set_req(1, 1'b1, 5'd12, 32'h0000_1234);
        drive_edge();
        req_valid = '0;
        drive_edge();
        set_req(1, 1'b1, 5'd12, 32'h0000_5555);
        drive_edge();
        req_valid = '0;
        #1 chk("mid_we_before", 32'(rf_we), 32'd1);
        rst_n = 1'b0;
        set_req(0, 1'b1, 5'd0, 32'h0);
        #1;
        chk("mid_we_dropped", 32'(rf_we), 32'd0);
        chk("mid_busy", busy_mask, 32'd0);
        chk("mid_ready_x0", 32'(req_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("mid_rf_x12", rf_mem[12], 32'h0000_1234);

        // Release and confirm arbitration restarts at requester 0.
        set_req(0, 1'b1, 5'd4, 32'h0000_0044);
        set_req(1, 1'b1, 5'd5, 32'h0000_0055);
        set_req(2, 1'b1, 5'd6, 32'h0000_0066);
        rst_n = 1'b1;
        #1 chk("rel_ready", 32'(req_ready), 32'b001);
        drive_edge();
        req_valid = '0;
        @(negedge clk);
        chk("rel_gid", 32'(grant_id), 32'd0);
        chk("rel_waddr", 32'(rf_waddr), 32'd4);
        drive_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
